quad_decoder: RTL and testbench

Quadrature decoder for a two-channel incremental rotary encoder on board I/O. It synchronizes and debounces channels A and B, then decodes the Gray-code phase sequence into a one-cycle STEP strobe plus a direction flag UP. These outputs drive the enable and UP inputs of the existing N-bit up/down counter. Illegal phase jumps set a sticky error flag.

---
 rtl/quad_decoder_pkg.sv | 24 ++
 rtl/quad_decoder_sync_debounce.sv | 41 ++++
 rtl/quad_decoder.sv | 96 +++++++++
 tb/tb_quad_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared types and Gray-code phase constants for the quadrature decoder.
package quad_pkg;

   typedef logic [1:0] phase_t;

   typedef enum logic {INIT, TRACK} state_t;

   // Phase codes are {A, B}; forward rotation walks 00 -> 01 -> 11 -> 10 -> 00.
   localparam phase_t PH_00 = 2'b00;
   localparam phase_t PH_01 = 2'b01;
   localparam phase_t PH_11 = 2'b11;
   localparam phase_t PH_10 = 2'b10;

   // Next phase in the forward direction; reverse neighbour is the inverse lookup.
   function automatic phase_t fwd_next(input phase_t p);
      case (p)
         PH_00:   return PH_01;
         PH_01:   return PH_11;
         PH_11:   return PH_10;
         default: return PH_00;
      endcase
   endfunction

endpackage

// File: rtl/quad_decoder_sync_debounce.sv
// Two-flop synchronizer followed by a stable-count debounce filter for one channel.
module sync_debounce
   import quad_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic RESET_N,
   input  logic d_in,
   output logic d_filt
);

   localparam int            CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_filt;

   // Synchronize, then accept a new level only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], d_in};
         if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_filt <= r_sync[1];
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign d_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounced A/B phases -> one-cycle STEP, direction UP, sticky ERR.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic RESET_N,
   input  logic A_IN,
   input  logic B_IN,
   input  logic EN,
   input  logic CLR_ERR,
   output logic STEP,
   output logic UP,
   output logic ERR
);

   // Startup window covers the synchronizer plus one full debounce, so the
   // filtered phase has settled before the first reference sample is taken.
   localparam int            IW        = $clog2(DEB_CYCLES + 3);
   localparam logic [IW-1:0] INIT_LAST = IW'(DEB_CYCLES + 2);

   logic    w_a_filt, w_b_filt;
   phase_t  w_phase;
   state_t  r_state, w_state_nxt;
   logic [IW-1:0] r_init_cnt;
   phase_t  r_prev;
   logic    w_fwd, w_rev, w_bad;
   logic    r_step, r_up, r_err;

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clk(clk), .RESET_N(RESET_N), .d_in(A_IN), .d_filt(w_a_filt)
   );

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk(clk), .RESET_N(RESET_N), .d_in(B_IN), .d_filt(w_b_filt)
   );

   assign w_phase = {w_a_filt, w_b_filt};

   // State register.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) r_state <= INIT;
      else          r_state <= w_state_nxt;
   end

   // Next state and phase-transition classification (only meaningful in TRACK).
   always_comb begin
      w_state_nxt = r_state;
      w_fwd       = 1'b0;
      w_rev       = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         INIT: begin
            if (r_init_cnt == INIT_LAST) w_state_nxt = TRACK;
         end
         TRACK: begin
            w_fwd = (fwd_next(r_prev) == w_phase);
            w_rev = (fwd_next(w_phase) == r_prev);
            w_bad = (w_phase == ~r_prev);
         end
         default: w_state_nxt = INIT;
      endcase
   end

   // Startup counter and previous-phase reference; prev is loaded on the INIT exit
   // and then every TRACK cycle, so tracking continues even while EN is low.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_init_cnt <= '0;
         r_prev     <= PH_00;
      end else begin
         if (r_state == INIT && r_init_cnt != INIT_LAST) r_init_cnt <= r_init_cnt + 1'b1;
         if (w_state_nxt == TRACK) r_prev <= w_phase;
      end
   end

   // Registered outputs; an illegal jump beats a same-cycle CLR_ERR.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_step <= 1'b0;
         r_up   <= 1'b1;
         r_err  <= 1'b0;
      end else begin
         r_step <= EN & (w_fwd | w_rev);
         if (EN & (w_fwd | w_rev)) r_up <= w_fwd;
         if (EN & w_bad)           r_err <= 1'b1;
         else if (CLR_ERR)         r_err <= 1'b0;
      end
   end

   assign STEP = r_step;
   assign UP   = r_up;
   assign ERR  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench: stimulus queues expected STEP/ERR events, a monitor matches them.
module tb_quad_decoder;

   localparam int DEB = 4;
   localparam int LAT = DEB + 3;   // drive at negedge c -> event visible at negedge c+LAT

   logic clk = 1'b0;
   logic RESET_N, A_IN, B_IN, EN, CLR_ERR;
   logic STEP, UP, ERR;

   quad_decoder #(.DEB_CYCLES(DEB)) dut (
      .clk(clk), .RESET_N(RESET_N), .A_IN(A_IN), .B_IN(B_IN), .EN(EN),
      .CLR_ERR(CLR_ERR), .STEP(STEP), .UP(UP), .ERR(ERR)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit is_err;
      bit up;
      int cyc;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit is_err, input bit up, input int at);
      ev_t e;
      e.is_err = is_err;
      e.up     = up;
      e.cyc    = at;
      q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Change inputs at a negedge and queue whatever response that change must produce.
   task automatic drive(input bit a, input bit b, input bit exp_step, input bit exp_up,
                        input bit exp_err);
      @(negedge clk);
      A_IN = a;
      B_IN = b;
      if (exp_step) push(1'b0, exp_up, cyc + LAT);
      if (exp_err)  push(1'b1, 1'b0, cyc + LAT);
   endtask

   // Monitor: every STEP pulse and every ERR rise must match the head of the queue.
   bit  prev_err = 1'b0;
   ev_t m_ev;
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_event: expected %s at cycle %0d was not observed",
                  q[0].is_err ? "ERR" : "STEP", q[0].cyc);
         void'(q.pop_front());
      end
      if (STEP) begin
         if (q.size() == 0 || q[0].is_err) begin
            chk("unexpected_step", STEP, 0);
         end else begin
            m_ev = q.pop_front();
            chk("step_cycle", cyc, m_ev.cyc);
            chk("step_up", UP, m_ev.up);
         end
      end
      if (ERR && !prev_err) begin
         if (q.size() == 0 || !q[0].is_err) begin
            chk("unexpected_err", ERR, 0);
         end else begin
            m_ev = q.pop_front();
            chk("err_cycle", cyc, m_ev.cyc);
         end
      end
      prev_err = ERR;
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      RESET_N = 1'b0; A_IN = 1'b1; B_IN = 1'b1; EN = 1'b1; CLR_ERR = 1'b0;

      // Reset values, then release with both channels high: nothing may fire.
      wait_cyc(3);
      chk("rst_step", STEP, 0);
      chk("rst_up", UP, 1);
      chk("rst_err", ERR, 0);
      RESET_N = 1'b1;
      wait_cyc(30);
      chk("init_queue", q.size(), 0);
      chk("init_up", UP, 1);
      chk("init_err", ERR, 0);

      // Re-reset with both channels low to start rotation tests from 00.
      RESET_N = 1'b0; A_IN = 1'b0; B_IN = 1'b0;
      wait_cyc(3);
      RESET_N = 1'b1;
      wait_cyc(20);

      // Forward rotation 00->01->11->10->00.
      drive(0, 1, 1, 1, 0); wait_cyc(9);
      drive(1, 1, 1, 1, 0); wait_cyc(9);
      drive(1, 0, 1, 1, 0); wait_cyc(9);
      drive(0, 0, 1, 1, 0); wait_cyc(12);
      chk("fwd_queue", q.size(), 0);
      chk("fwd_up", UP, 1);

      // Reverse rotation 00->10->11->01, UP must hold 0 afterwards.
      drive(1, 0, 1, 0, 0); wait_cyc(9);
      drive(1, 1, 1, 0, 0); wait_cyc(9);
      drive(0, 1, 1, 0, 0); wait_cyc(12);
      chk("rev_queue", q.size(), 0);
      chk("rev_up_hold", UP, 0);
      drive(0, 0, 1, 0, 0); wait_cyc(12);

      // Glitch rejection from phase 01: 3-cycle A pulse ignored, 4-cycle A pulse accepted.
      drive(0, 1, 1, 1, 0); wait_cyc(12);
      @(negedge clk); A_IN = 1'b1;
      wait_cyc(3);    A_IN = 1'b0;
      wait_cyc(15);
      @(negedge clk); A_IN = 1'b1; push(1'b0, 1'b1, cyc + LAT);
      wait_cyc(4);    A_IN = 1'b0; push(1'b0, 1'b0, cyc + LAT);
      wait_cyc(15);
      chk("glitch_queue", q.size(), 0);
      chk("glitch_up", UP, 0);
      drive(0, 0, 1, 0, 0); wait_cyc(12);

      // Illegal jump 00->11, then CLR_ERR clears it.
      drive(1, 1, 0, 0, 1); wait_cyc(12);
      chk("ill_err", ERR, 1);
      chk("ill_up_hold", UP, 0);
      @(negedge clk); CLR_ERR = 1'b1;
      @(negedge clk); CLR_ERR = 1'b0;
      wait_cyc(2);
      chk("clr_err", ERR, 0);

      // Illegal jump 11->00 with CLR_ERR asserted on the detection edge: set wins.
      drive(0, 0, 0, 0, 1);
      wait_cyc(6); CLR_ERR = 1'b1;
      wait_cyc(1); CLR_ERR = 1'b0;
      wait_cyc(5);
      chk("set_wins_err", ERR, 1);
      @(negedge clk); CLR_ERR = 1'b1;
      @(negedge clk); CLR_ERR = 1'b0;
      wait_cyc(2);
      chk("clr_err2", ERR, 0);

      // EN gating: two forward moves suppressed, third produces exactly one step.
      @(negedge clk); EN = 1'b0;
      drive(0, 1, 0, 0, 0); wait_cyc(9);
      drive(1, 1, 0, 0, 0); wait_cyc(9);
      @(negedge clk); EN = 1'b1;
      wait_cyc(3);
      drive(1, 0, 1, 1, 0); wait_cyc(12);
      chk("en_queue", q.size(), 0);
      chk("en_up", UP, 1);

      // Set ERR and UP=0 so an async reset has something to clear.
      drive(0, 1, 0, 0, 1); wait_cyc(12);
      drive(0, 0, 1, 0, 0); wait_cyc(12);
      chk("pre_rst_err", ERR, 1);
      chk("pre_rst_up", UP, 0);

      // Async reset in the middle of a debounce: outputs change without a clock edge.
      drive(0, 1, 0, 0, 0);
      wait_cyc(3);
      #1 RESET_N = 1'b0;
      #2;
      chk("arst_step", STEP, 0);
      chk("arst_up", UP, 1);
      chk("arst_err", ERR, 0);
      wait_cyc(3);
      RESET_N = 1'b1;
      wait_cyc(20);
      chk("post_rst_queue", q.size(), 0);
      chk("post_rst_err", ERR, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
